// File: rtl/key_pkg.sv
// Shared constants, FSM state encoding and code-to-direction map for the keypad event decoder.
package key_pkg;

  localparam logic [2:0] DIR_NONE  = 3'd0;
  localparam logic [2:0] DIR_UP    = 3'd1;
  localparam logic [2:0] DIR_DOWN  = 3'd2;
  localparam logic [2:0] DIR_LEFT  = 3'd3;
  localparam logic [2:0] DIR_RIGHT = 3'd4;

  localparam logic [3:0] KEY_UP    = 4'h1;
  localparam logic [3:0] KEY_DOWN  = 4'h5;
  localparam logic [3:0] KEY_LEFT  = 4'h4;
  localparam logic [3:0] KEY_RIGHT = 4'h6;

  // Event word layout: {code[3:0], dir[2:0]}
  localparam int unsigned EV_W = 7;

  typedef enum logic [1:0] {
    IDLE,
    DEBOUNCE,
    HELD,
    RELEASE_WAIT
  } key_state_t;

  function automatic logic [2:0] code_to_dir(input logic [3:0] code);
    logic [2:0] dir;
    dir = DIR_NONE;
    case (code)
      KEY_UP:    dir = DIR_UP;
      KEY_DOWN:  dir = DIR_DOWN;
      KEY_LEFT:  dir = DIR_LEFT;
      KEY_RIGHT: dir = DIR_RIGHT;
      default:   dir = DIR_NONE;
    endcase
    return dir;
  endfunction

endpackage

// File: rtl/key_event_fifo.sv
// First-word fall-through event FIFO; head reads as zero while empty.
module key_event_fifo
  import key_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned W          = EV_W
) (
  input  logic         CLK,
  input  logic         ASYNC_RST_L,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

  logic [W-1:0]  mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(FIFO_DEPTH));
  assign do_pop  = pop & ~empty;
  // A push into a full FIFO is still taken when the head leaves in the same cycle.
  assign do_push = push & (~full | do_pop);
  assign dout    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge CLK or negedge ASYNC_RST_L) begin
    if (!ASYNC_RST_L) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      count <= count + CW'(1);
      else if (do_pop && !do_push) count <= count - CW'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/key_event_decoder.sv
// Debounces keypad scanner output into press events queued toward the game controller.
// Optional auto-repeat while a key is held: define KEY_AUTOREPEAT_EN.
module key_event_decoder
  import key_pkg::*;
#(
  parameter int unsigned DEB_CYCLES    = 16,
  parameter int unsigned REL_CYCLES    = 16,
  parameter int unsigned FIFO_DEPTH    = 4,
  parameter int unsigned REPEAT_DELAY  = 512,
  parameter int unsigned REPEAT_PERIOD = 128
) (
  input  logic       CLK,
  input  logic       ASYNC_RST_L,
  input  logic       DET,
  input  logic [3:0] CODE,
  output logic       EV_VALID,
  input  logic       EV_READY,
  output logic [3:0] EV_CODE,
  output logic [2:0] EV_DIR,
  output logic       KEY_HELD,
  output logic [3:0] HELD_CODE,
  output logic       OVF,
  input  logic       OVF_CLR
);

  localparam int unsigned CNT_MAX = (DEB_CYCLES > REL_CYCLES) ? DEB_CYCLES : REL_CYCLES;
  localparam int unsigned CW      = $clog2(CNT_MAX);

  if (DEB_CYCLES < 2 || REL_CYCLES < 4 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_cfg
    $error("key_event_decoder: invalid timing parameters");
  end

  key_state_t    state, state_d;
  logic [3:0]    cand, cand_d;
  logic [CW-1:0] cnt, cnt_d, cnt_inc;
  logic          key_held_d;
  logic [3:0]    held_code_d;
  logic          deb_push;
  logic          rep_fire;
  logic          push;
  logic [3:0]    push_code;
  logic          fifo_full, fifo_empty;
  logic          drop;
  logic [EV_W-1:0] head;

  assign cnt_inc = (cnt == '1) ? cnt : cnt + CW'(1);

  always_comb begin
    state_d     = state;
    cand_d      = cand;
    cnt_d       = cnt;
    key_held_d  = KEY_HELD;
    held_code_d = HELD_CODE;
    deb_push    = 1'b0;
    case (state)
      IDLE: begin
        if (DET) begin
          state_d = DEBOUNCE;
          cand_d  = CODE;
          cnt_d   = CW'(1);
        end
      end
      DEBOUNCE: begin
        if (!DET) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (CODE != cand) begin
          cand_d = CODE;
          cnt_d  = CW'(1);
        end else if (cnt == CW'(DEB_CYCLES - 1)) begin
          state_d     = HELD;
          deb_push    = 1'b1;
          key_held_d  = 1'b1;
          held_code_d = cand;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      HELD: begin
        if (!DET) begin
          state_d = RELEASE_WAIT;
          cnt_d   = CW'(1);
        end
      end
      RELEASE_WAIT: begin
        if (DET) begin
          state_d = HELD;
        end else if (cnt == CW'(REL_CYCLES - 1)) begin
          state_d    = IDLE;
          key_held_d = 1'b0;
          cnt_d      = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge ASYNC_RST_L) begin
    if (!ASYNC_RST_L) begin
      state     <= IDLE;
      cand      <= '0;
      cnt       <= '0;
      KEY_HELD  <= 1'b0;
      HELD_CODE <= '0;
    end else begin
      state     <= state_d;
      cand      <= cand_d;
      cnt       <= cnt_d;
      KEY_HELD  <= key_held_d;
      HELD_CODE <= held_code_d;
    end
  end

`ifdef KEY_AUTOREPEAT_EN
  localparam int unsigned REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RW      = (REP_MAX > 1) ? $clog2(REP_MAX) : 1;

  logic [RW-1:0] rep_cnt;
  logic          rep_armed;

  // First repeat waits REPEAT_DELAY, later ones REPEAT_PERIOD; release bounce only pauses the count.
  assign rep_fire = (state == HELD) &&
                    (rep_armed ? (rep_cnt == RW'(REPEAT_PERIOD - 1))
                               : (rep_cnt == RW'(REPEAT_DELAY - 1)));

  always_ff @(posedge CLK or negedge ASYNC_RST_L) begin
    if (!ASYNC_RST_L) begin
      rep_cnt   <= '0;
      rep_armed <= 1'b0;
    end else if (state == IDLE || state == DEBOUNCE) begin
      rep_cnt   <= '0;
      rep_armed <= 1'b0;
    end else if (state == HELD) begin
      if (rep_fire) begin
        rep_cnt   <= '0;
        rep_armed <= 1'b1;
      end else if (rep_cnt != '1) begin
        rep_cnt <= rep_cnt + RW'(1);
      end
    end
  end
`else
  assign rep_fire = 1'b0;
`endif

  assign push      = deb_push | rep_fire;
  assign push_code = deb_push ? cand : HELD_CODE;
  assign drop      = push & fifo_full & ~EV_READY;

  key_event_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .W          (EV_W)
  ) u_fifo (
    .CLK         (CLK),
    .ASYNC_RST_L (ASYNC_RST_L),
    .push        (push),
    .din         ({push_code, code_to_dir(push_code)}),
    .pop         (EV_READY),
    .dout        (head),
    .full        (fifo_full),
    .empty       (fifo_empty)
  );

  assign EV_VALID = ~fifo_empty;
  assign EV_CODE  = head[6:3];
  assign EV_DIR   = head[2:0];

  always_ff @(posedge CLK or negedge ASYNC_RST_L) begin
    if (!ASYNC_RST_L)  OVF <= 1'b0;
    else if (drop)     OVF <= 1'b1;
    else if (OVF_CLR)  OVF <= 1'b0;
  end

endmodule
